// File: rtl/neuron_grid_param_if.sv
// Bus bundle for neuron_grid_param.
// Carries tick/spike input, the three configuration write ports
// (param/syn/type), downstream backpressure and the packet/status outputs.
// master: the driver of the core (tick source, config loader, router side).
// slave : the neuron grid itself.
interface neuron_grid_param_if #(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256
);
  localparam int NB = $clog2(NUM_NEURONS);
  localparam int WB = $clog2(NUM_AXONS / 32);
  localparam int AB = $clog2(NUM_AXONS);

  logic                 tick;
  logic [NUM_AXONS-1:0] axon_spikes;
  logic                 local_buffers_full;
  logic                 param_wen;
  logic [NB+2:0]        param_addr;
  logic [31:0]          param_data_in;
  logic                 syn_wen;
  logic [NB+WB-1:0]     syn_addr;
  logic [31:0]          syn_data_in;
  logic                 type_wen;
  logic [AB-1:0]        type_addr;
  logic [1:0]           type_data_in;
  logic [29:0]          packet_out;
  logic                 spike_out_valid;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    output tick, axon_spikes, local_buffers_full,
    output param_wen, param_addr, param_data_in,
    output syn_wen, syn_addr, syn_data_in,
    output type_wen, type_addr, type_data_in,
    input  packet_out, spike_out_valid, busy, done, error
  );

  modport slave (
    input  tick, axon_spikes, local_buffers_full,
    input  param_wen, param_addr, param_data_in,
    input  syn_wen, syn_addr, syn_data_in,
    input  type_wen, type_addr, type_data_in,
    output packet_out, spike_out_valid, busy, done, error
  );
endinterface

// File: rtl/neuron_grid_param.sv
// Leaky integrate-and-fire neuron grid for one core.
// Each accepted tick integrates the latched spike vector into every neuron's
// membrane potential (one axon per cycle), applies leak, fires against the
// threshold and emits a routing packet for each fired neuron.
// Ports: clk, reset (async, active-high), bus (neuron_grid_param_if.slave):
//   tick/axon_spikes      start of timestep + spike vector
//   param/syn/type_*      run-time configuration writes (dropped while busy)
//   local_buffers_full    backpressure on packet_out/spike_out_valid
//   busy/done/error       status; error is sticky until reset
// Optional feature: define NEURON_GRID_NEG_THR_EN to enable the per-neuron
// negative threshold (param field 6) that floors the potential after leak.
module neuron_grid_param #(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256,
  parameter int POT_W       = 9,
  parameter int CORE_NUMBER = 0
) (
  input logic                 clk,
  input logic                 reset,
  neuron_grid_param_if.slave  bus
);
  localparam int NB    = $clog2(NUM_NEURONS);
  localparam int AB    = $clog2(NUM_AXONS);
  localparam int WORDS = NUM_AXONS / 32;
  localparam int WB    = $clog2(WORDS);
  localparam int WBS   = (WB > 0) ? WB : 1;

  typedef logic signed [POT_W-1:0] pot_t;
  typedef enum logic [2:0] {IDLE, INTEG, FIRE, EMIT, NEXT} state_t;

  localparam pot_t POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
  localparam pot_t POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

  // Configuration storage (not reset)
  pot_t                 w_ram    [NUM_NEURONS][4];
  pot_t                 leak_ram [NUM_NEURONS];
  pot_t                 thr_ram  [NUM_NEURONS];
  pot_t                 rst_ram  [NUM_NEURONS];
  logic [29:0]          dest_ram [NUM_NEURONS];
  logic [NUM_AXONS-1:0] conn_ram [NUM_NEURONS];
  logic [1:0]           type_ram [NUM_AXONS];
`ifdef NEURON_GRID_NEG_THR_EN
  pot_t                 nt_ram   [NUM_NEURONS];
`endif

  // Run state
  state_t               state, state_nx;
  pot_t                 pot [NUM_NEURONS];
  logic [NUM_AXONS-1:0] spikes_q;
  logic [NB-1:0]        neuron;
  logic [AB-1:0]        axon;
  logic [29:0]          pkt_q;
  logic                 err_q;

  logic                 busy_c, done_c, valid_c;
  logic                 last_axon, last_neuron, hit, fire;
  pot_t                 fire_pot;
  logic [NB-1:0]        p_n, s_n;
  logic [WBS-1:0]       syn_word;
  logic                 unused_ok;

  function automatic pot_t sat_add(input pot_t a, input pot_t b);
    logic signed [POT_W:0] s;
    s = {a[POT_W-1], a} + {b[POT_W-1], b};
    if (s[POT_W] != s[POT_W-1]) return s[POT_W] ? POT_MIN : POT_MAX;
    return s[POT_W-1:0];
  endfunction

  assign last_axon   = (axon == AB'(NUM_AXONS - 1));
  assign last_neuron = (neuron == NB'(NUM_NEURONS - 1));
  assign hit         = spikes_q[axon] && conn_ram[neuron][axon];
  assign p_n         = bus.param_addr[NB+2:3];
  assign s_n         = bus.syn_addr[NB+WB-1 -: NB];
  assign unused_ok   = ^{bus.param_data_in[31:30], 32'(CORE_NUMBER)};

  if (WB > 0) begin : g_word
    assign syn_word = bus.syn_addr[WBS-1:0];
  end else begin : g_word_single
    assign syn_word = '0;
  end

  always_comb begin
    fire_pot = sat_add(pot[neuron], leak_ram[neuron]);
`ifdef NEURON_GRID_NEG_THR_EN
    if (fire_pot < -nt_ram[neuron]) fire_pot = -nt_ram[neuron];
`endif
    fire = (fire_pot >= thr_ram[neuron]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FIRE/EMIT step straight into the next neuron's INTEG; NEXT is only
  // visited once, after the last neuron, as the done/idle-return cycle.
  // This gives N*(A+1) + F + 1 cycles from tick to done.
  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    valid_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tick) state_nx = INTEG;
      end
      NEXT: begin
        done_c   = 1'b1;
        state_nx = bus.tick ? INTEG : IDLE;
      end
      INTEG: begin
        busy_c = 1'b1;
        if (last_axon) state_nx = FIRE;
      end
      FIRE: begin
        busy_c = 1'b1;
        if (fire)             state_nx = EMIT;
        else if (last_neuron) state_nx = NEXT;
        else                  state_nx = INTEG;
      end
      EMIT: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        if (!bus.local_buffers_full) state_nx = last_neuron ? NEXT : INTEG;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy            = busy_c;
  assign bus.done            = done_c;
  assign bus.spike_out_valid = valid_c;
  assign bus.packet_out      = pkt_q;
  assign bus.error           = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
      spikes_q <= '0;
      neuron   <= '0;
      axon     <= '0;
      pkt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (busy_c && (bus.tick || bus.param_wen || bus.syn_wen || bus.type_wen))
        err_q <= 1'b1;
      case (state)
        IDLE, NEXT: begin
          if (bus.tick) begin
            spikes_q <= bus.axon_spikes;
            neuron   <= '0;
            axon     <= '0;
          end
        end
        INTEG: begin
          if (hit) pot[neuron] <= sat_add(pot[neuron], w_ram[neuron][type_ram[axon]]);
          axon <= last_axon ? '0 : axon + AB'(1);
        end
        FIRE: begin
          pot[neuron] <= fire ? rst_ram[neuron] : fire_pot;
          if (fire)              pkt_q  <= dest_ram[neuron];
          else if (!last_neuron) neuron <= neuron + NB'(1);
        end
        EMIT: begin
          if (!bus.local_buffers_full && !last_neuron) neuron <= neuron + NB'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bus.param_wen && !busy_c) begin
      case (bus.param_addr[2:0])
        3'd0: begin
          w_ram[p_n][0] <= bus.param_data_in[POT_W-1:0];
          w_ram[p_n][1] <= bus.param_data_in[16 +: POT_W];
        end
        3'd1: begin
          w_ram[p_n][2] <= bus.param_data_in[POT_W-1:0];
          w_ram[p_n][3] <= bus.param_data_in[16 +: POT_W];
        end
        3'd2: leak_ram[p_n] <= bus.param_data_in[POT_W-1:0];
        3'd3: thr_ram[p_n]  <= bus.param_data_in[POT_W-1:0];
        3'd4: rst_ram[p_n]  <= bus.param_data_in[POT_W-1:0];
        3'd5: dest_ram[p_n] <= bus.param_data_in[29:0];
`ifdef NEURON_GRID_NEG_THR_EN
        3'd6: nt_ram[p_n]   <= bus.param_data_in[POT_W-1:0];
`endif
        default: ;
      endcase
    end
    if (bus.syn_wen && !busy_c) begin
      for (int unsigned k = 0; k < WORDS; k++)
        if (32'(syn_word) == k) conn_ram[s_n][k*32 +: 32] <= bus.syn_data_in;
    end
    if (bus.type_wen && !busy_c) type_ram[bus.type_addr] <= bus.type_data_in;
  end
endmodule

// File: tb/tb_neuron_grid_param.sv
// Directed bench for neuron_grid_param (32 axons, 4 neurons, 9-bit potentials).
// Vector table covers integration, weight types, leak, threshold boundary,
// saturation and backpressure; hand sequences cover protocol errors,
// back-to-back ticks, reset mid-run and simultaneous config writes.
module tb_neuron_grid_param;
  localparam int A = 32;
  localparam int N = 4;
  localparam int P = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neuron_grid_param_if #(.NUM_AXONS(A), .NUM_NEURONS(N)) bus ();

  neuron_grid_param #(
    .NUM_AXONS(A), .NUM_NEURONS(N), .POT_W(P), .CORE_NUMBER(0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          nrn;
    logic [31:0] spikes;
    logic [31:0] conn;
    int          w0, w1, w2, w3, leak, thr, rstp;
    int          stall;
    int          exp_lat;
    int          exp_pk;
    int          exp_pot;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] dest_of(input int n);
    return 30'h15A5A5A0 ^ 30'(n);
  endfunction

  function automatic vec_t mk(input int nrn, input logic [31:0] spikes, input logic [31:0] conn,
                              input int w0, input int w1, input int w2, input int w3,
                              input int leak, input int thr, input int rstp, input int stall,
                              input int exp_lat, input int exp_pk, input int exp_pot);
    vec_t v;
    v.nrn = nrn; v.spikes = spikes; v.conn = conn;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.leak = leak; v.thr = thr; v.rstp = rstp; v.stall = stall;
    v.exp_lat = exp_lat; v.exp_pk = exp_pk; v.exp_pot = exp_pot;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_param(input int n, input int f, input logic [31:0] d);
    bus.param_wen     = 1'b1;
    bus.param_addr    = 5'(n * 8 + f);
    bus.param_data_in = d;
    step();
    bus.param_wen     = 1'b0;
  endtask

  task automatic wr_syn(input int n, input logic [31:0] d);
    bus.syn_wen     = 1'b1;
    bus.syn_addr    = 2'(n);
    bus.syn_data_in = d;
    step();
    bus.syn_wen     = 1'b0;
  endtask

  task automatic wr_type(input int a, input int t);
    bus.type_wen     = 1'b1;
    bus.type_addr    = 5'(a);
    bus.type_data_in = 2'(t);
    step();
    bus.type_wen     = 1'b0;
  endtask

  task automatic cfg_neuron(input int n, input int w0, input int w1, input int w2, input int w3,
                            input int leak, input int thr, input int rstp, input logic [31:0] conn);
    wr_param(n, 0, {7'b0, 9'(w1), 7'b0, 9'(w0)});
    wr_param(n, 1, {7'b0, 9'(w3), 7'b0, 9'(w2)});
    wr_param(n, 2, {23'b0, 9'(leak)});
    wr_param(n, 3, {23'b0, 9'(thr)});
    wr_param(n, 4, {23'b0, 9'(rstp)});
    wr_param(n, 5, {2'b0, dest_of(n)});
    wr_param(n, 6, 32'd20);
    wr_syn(n, conn);
  endtask

  task automatic cfg_all_neutral_except(input int keep);
    for (int n = 0; n < N; n++)
      if (n != keep) cfg_neuron(n, 0, 0, 0, 0, 0, 255, 0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic start_tick(input logic [31:0] spikes);
    bus.axon_spikes = spikes;
    bus.tick        = 1'b1;
    step();
    bus.tick        = 1'b0;
    check("busy_after_tick", 32'(bus.busy), 32'd1);
  endtask

  // Counts cycles from the tick (cycle 0) until done is seen; holds full for
  // 'stall' cycles at the first valid packet.
  task automatic wait_done(input int stall, input logic [29:0] exp_pkt, input int start_cyc,
                           output int lat, output int npk, output int pkbad);
    int c;
    int st;
    c = start_cyc; st = 0; lat = -1; npk = 0; pkbad = 0;
    while (c < 600) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.spike_out_valid) begin
        if (bus.packet_out !== exp_pkt) pkbad++;
        if (st < stall) begin
          bus.local_buffers_full = 1'b1;
          st++;
        end else begin
          bus.local_buffers_full = 1'b0;
          npk++;
        end
      end else begin
        bus.local_buffers_full = 1'b0;
      end
      step();
      c++;
    end
    bus.local_buffers_full = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, npk, pkbad;
    int neg_exp;
    vec_t v;

`ifdef NEURON_GRID_NEG_THR_EN
    neg_exp = -20;
`else
    neg_exp = -50;
`endif
    //            nrn spikes        conn          w0    w1    w2    w3   leak thr rst stall lat pk pot
    vecs[0]  = mk(0, 32'h7,        32'h7,         5,    0,    0,    0,   0,  10, 0,  0,  134, 1, 0);
    vecs[1]  = mk(0, 32'h7,        32'h7,         5,    0,    0,    0,   0,  10, 0,  10, 144, 1, 0);
    vecs[2]  = mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF,  200,  200,  200,  200, 0, 255, 7,  0,  134, 1, 7);
    vecs[3]  = mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF,  200,  200,  200,  200, -1, 255, 7, 0,  133, 0, 254);
    vecs[4]  = mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF,  -200, -200, -200, -200, 0, 255, 0, 0,  133, 0, -256);
    vecs[5]  = mk(0, 32'h0,        32'h0,         0,    0,    0,    0,  -50, 255, 0, 0,  133, 0, neg_exp);
    vecs[6]  = mk(0, 32'h5,        32'h7,         5,    0,    0,    0,   0,  10, 3,  0,  134, 1, 3);
    vecs[7]  = mk(0, 32'h5,        32'h7,         5,    0,    0,    0,   0,  11, 3,  0,  133, 0, 10);
    vecs[8]  = mk(0, 32'h38,       32'h3F,        5,    1,    2,    4,   0, 255, 0,  0,  133, 0, 7);
    vecs[9]  = mk(0, 32'h3F,       32'h2A,        5,    1,    2,    4,   0, 255, 0,  0,  133, 0, 10);
    vecs[10] = mk(3, 32'h7,        32'h7,         5,    0,    0,    0,   0,  10, 0,  0,  134, 1, 0);
    vecs[11] = mk(1, 32'h0,        32'h0,         0,    0,    0,    0,  10,  10, -5, 0,  134, 1, -5);

    bus.tick = 1'b0; bus.axon_spikes = '0; bus.local_buffers_full = 1'b0;
    bus.param_wen = 1'b0; bus.param_addr = '0; bus.param_data_in = '0;
    bus.syn_wen = 1'b0; bus.syn_addr = '0; bus.syn_data_in = '0;
    bus.type_wen = 1'b0; bus.type_addr = '0; bus.type_data_in = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_valid", 32'(bus.spike_out_valid), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_pkt",   32'(bus.packet_out), 32'd0);
    check("rst_pot0",  32'(dut.pot[0]), 32'd0);

    // Axon types: 3->1, 4->2, 5->3, rest 0
    for (int a = 0; a < A; a++)
      wr_type(a, (a == 3) ? 1 : (a == 4) ? 2 : (a == 5) ? 3 : 0);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      do_reset();
      cfg_all_neutral_except(v.nrn);
      cfg_neuron(v.nrn, v.w0, v.w1, v.w2, v.w3, v.leak, v.thr, v.rstp, v.conn);
      start_tick(v.spikes);
      wait_done(v.stall, dest_of(v.nrn), 1, lat, npk, pkbad);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d_packets", i), 32'(npk), 32'(v.exp_pk));
      check($sformatf("v%0d_pkt_stable", i), 32'(pkbad), 32'd0);
      check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_pot", i), 32'(dut.pot[v.nrn]), 32'(v.exp_pot));
      step();
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Accumulation across back-to-back ticks (second tick on the done cycle),
    // then reset mid-INTEG and a fresh tick.
    do_reset();
    cfg_all_neutral_except(0);
    cfg_neuron(0, 5, 0, 0, 0, 0, 255, 0, 32'h7);
    start_tick(32'h7);
    wait_done(0, dest_of(0), 1, lat, npk, pkbad);
    check("acc1_latency", 32'(lat), 32'd133);
    check("acc1_pot", 32'(dut.pot[0]), 32'd15);
    start_tick(32'h7);
    check("b2b_error", 32'(bus.error), 32'd0);
    wait_done(0, dest_of(0), 1, lat, npk, pkbad);
    check("acc2_latency", 32'(lat), 32'd133);
    check("acc2_pot", 32'(dut.pot[0]), 32'd30);
    start_tick(32'h7);
    repeat (5) step();
    reset = 1'b1;
    step();
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_valid", 32'(bus.spike_out_valid), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_pot", 32'(dut.pot[0]), 32'd0);
    reset = 1'b0;
    step();
    start_tick(32'h7);
    wait_done(0, dest_of(0), 1, lat, npk, pkbad);
    check("fresh_latency", 32'(lat), 32'd133);
    check("fresh_pot", 32'(dut.pot[0]), 32'd15);

    // Reset while a packet is stalled in EMIT
    do_reset();
    cfg_neuron(0, 5, 0, 0, 0, 0, 10, 0, 32'h7);
    start_tick(32'h7);
    bus.local_buffers_full = 1'b1;
    for (int c = 0; c < 200 && !bus.spike_out_valid; c++) step();
    check("stall_valid", 32'(bus.spike_out_valid), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("emitrst_valid", 32'(bus.spike_out_valid), 32'd0);
    check("emitrst_pkt", 32'(bus.packet_out), 32'd0);
    bus.local_buffers_full = 1'b0;
    reset = 1'b0;
    step();

    // Simultaneous param/syn/type writes in IDLE all take effect
    do_reset();
    cfg_neuron(0, 5, 0, 0, 0, 0, 255, 0, 32'h0);
    wr_type(1, 1);
    bus.param_wen = 1'b1; bus.param_addr = 5'd3; bus.param_data_in = 32'd10;
    bus.syn_wen   = 1'b1; bus.syn_addr   = 2'd0; bus.syn_data_in   = 32'h3;
    bus.type_wen  = 1'b1; bus.type_addr  = 5'd1; bus.type_data_in  = 2'd0;
    step();
    bus.param_wen = 1'b0; bus.syn_wen = 1'b0; bus.type_wen = 1'b0;
    start_tick(32'h3);
    wait_done(0, dest_of(0), 1, lat, npk, pkbad);
    check("simul_latency", 32'(lat), 32'd134);
    check("simul_packets", 32'(npk), 32'd1);
    check("simul_pot", 32'(dut.pot[0]), 32'd0);

    // Tick and param write while busy: error, ignored, run unaffected
    do_reset();
    cfg_neuron(0, 5, 0, 0, 0, 0, 10, 0, 32'h7);
    check("err_clear", 32'(bus.error), 32'd0);
    start_tick(32'h7);
    repeat (4) step();
    bus.tick = 1'b1;
    bus.param_wen = 1'b1; bus.param_addr = 5'd3; bus.param_data_in = 32'd100;
    step();
    bus.tick = 1'b0;
    bus.param_wen = 1'b0;
    check("err_set", 32'(bus.error), 32'd1);
    wait_done(0, dest_of(0), 6, lat, npk, pkbad);
    check("err_latency", 32'(lat), 32'd134);
    check("err_packets", 32'(npk), 32'd1);
    step();
    step();
    check("err_sticky", 32'(bus.error), 32'd1);
    check("err_idle", 32'(bus.busy), 32'd0);
    do_reset();
    check("err_after_reset", 32'(bus.error), 32'd0);
    start_tick(32'h7);
    wait_done(0, dest_of(0), 1, lat, npk, pkbad);
    check("ram_kept_packets", 32'(npk), 32'd1);
    check("ram_kept_pot", 32'(dut.pot[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
